// File: rtl/branch_checkpoint_stack.sv
// Branch checkpoint stack: DEPTH in-flight checkpoints, NUM_RESOLVE resolves per cycle,
// oldest-mispredict recovery with combinational restore of the winning checkpoint.
module branch_checkpoint_slot #(
    parameter int DEPTH     = 4,
    parameter int ROB_IDX_W = 5,
    parameter int LSQ_IDX_W = 4,
    parameter int PREGS     = 64,
    parameter int MAP_W     = 192,
    parameter int ADDR_W    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_en,
    input  logic                 keep,
    input  logic [DEPTH-1:0]     dep_init,
    input  logic [DEPTH-1:0]     clear_bits,
    input  logic [ROB_IDX_W-1:0] alloc_rob_tail,
    input  logic [LSQ_IDX_W-1:0] alloc_lsq_tail,
    input  logic [PREGS-1:0]     alloc_free_list,
    input  logic [MAP_W-1:0]     alloc_map_table,
    input  logic [ADDR_W-1:0]    alloc_recovery_pc,
    input  logic [PREGS-1:0]     retire_free,
    output logic                 valid,
    output logic [DEPTH-1:0]     dep,
    output logic [ROB_IDX_W-1:0] rob_tail,
    output logic [LSQ_IDX_W-1:0] lsq_tail,
    output logic [PREGS-1:0]     free_list,
    output logic [MAP_W-1:0]     map_table,
    output logic [ADDR_W-1:0]    recovery_pc
);
    always_ff @(posedge clock) begin
        if (reset) begin
            valid       <= 1'b0;
            dep         <= '0;
            rob_tail    <= '0;
            lsq_tail    <= '0;
            free_list   <= '0;
            map_table   <= '0;
            recovery_pc <= '0;
        end else if (alloc_en) begin
            valid       <= 1'b1;
            dep         <= dep_init;
            rob_tail    <= alloc_rob_tail;
            lsq_tail    <= alloc_lsq_tail;
            free_list   <= alloc_free_list | retire_free;
            map_table   <= alloc_map_table;
            recovery_pc <= alloc_recovery_pc;
        end else begin
            valid <= keep;
            dep   <= dep & ~clear_bits;
            // Registers retired while this branch is in flight must be free after recovery.
            if (keep)
                free_list <= free_list | retire_free;
        end
    end
endmodule

module branch_checkpoint_stack #(
    parameter int DEPTH       = 4,
    parameter int NUM_RESOLVE = 2,
    parameter int ROB_IDX_W   = 5,
    parameter int LSQ_IDX_W   = 4,
    parameter int PREGS       = 64,
    parameter int ARCH_REGS   = 32,
    parameter int PREG_W      = 6,
    parameter int ADDR_W      = 32,
    localparam int CNT_W      = $clog2(DEPTH+1),
    localparam int MAP_W      = ARCH_REGS*PREG_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         alloc_req,
    input  logic [ROB_IDX_W-1:0]         alloc_rob_tail,
    input  logic [LSQ_IDX_W-1:0]         alloc_lsq_tail,
    input  logic [PREGS-1:0]             alloc_free_list,
    input  logic [MAP_W-1:0]             alloc_map_table,
    input  logic [ADDR_W-1:0]            alloc_recovery_pc,
    output logic                         alloc_grant,
    output logic [DEPTH-1:0]             alloc_tag,
    output logic [DEPTH-1:0]             cur_b_mask,
    output logic [CNT_W-1:0]             free_count,
    input  logic [NUM_RESOLVE-1:0]       rslv_valid,
    input  logic [NUM_RESOLVE*DEPTH-1:0] rslv_tag,
    input  logic [NUM_RESOLVE-1:0]       rslv_mispred,
    input  logic [PREGS-1:0]             retire_free,
    output logic [DEPTH-1:0]             clear_mask,
    output logic                         restore_valid,
    output logic [DEPTH-1:0]             squash_mask,
    output logic [ROB_IDX_W-1:0]         restore_rob_tail,
    output logic [LSQ_IDX_W-1:0]         restore_lsq_tail,
    output logic [PREGS-1:0]             restore_free_list,
    output logic [MAP_W-1:0]             restore_map_table,
    output logic [ADDR_W-1:0]            restore_pc
);
    logic [DEPTH-1:0]                valid;
    logic [DEPTH-1:0][DEPTH-1:0]     slot_dep;
    logic [DEPTH-1:0][ROB_IDX_W-1:0] slot_rob;
    logic [DEPTH-1:0][LSQ_IDX_W-1:0] slot_lsq;
    logic [DEPTH-1:0][PREGS-1:0]     slot_fl;
    logic [DEPTH-1:0][MAP_W-1:0]     slot_map;
    logic [DEPTH-1:0][ADDR_W-1:0]    slot_pc;

    logic [DEPTH-1:0] mis_set, cor_set, win, first_free, keep;
    logic [PREGS-1:0] win_fl;
    logic [CNT_W-1:0] next_free;

    // Tags that miss every valid slot drop out here, so stale resolves are harmless.
    always_comb begin
        mis_set = '0;
        cor_set = '0;
        for (int c = 0; c < NUM_RESOLVE; c++) begin
            if (rslv_valid[c]) begin
                if (rslv_mispred[c]) mis_set |= rslv_tag[c*DEPTH +: DEPTH] & valid;
                else                 cor_set |= rslv_tag[c*DEPTH +: DEPTH] & valid;
            end
        end
    end

    // The oldest mispredict is the one that depends on no other mispredicting slot.
    always_comb begin
        win         = '0;
        squash_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            win[i] = mis_set[i] && ((slot_dep[i] & mis_set) == '0);
        for (int j = 0; j < DEPTH; j++)
            squash_mask[j] = win[j] | (valid[j] && ((slot_dep[j] & win) != '0));
    end

    assign restore_valid = |mis_set;
    assign clear_mask    = cor_set & ~squash_mask;
    assign keep          = valid & ~clear_mask & ~squash_mask;

    always_comb begin
        restore_rob_tail  = '0;
        restore_lsq_tail  = '0;
        restore_map_table = '0;
        restore_pc        = '0;
        win_fl            = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (win[i]) begin
                restore_rob_tail  |= slot_rob[i];
                restore_lsq_tail  |= slot_lsq[i];
                restore_map_table |= slot_map[i];
                restore_pc        |= slot_pc[i];
                win_fl            |= slot_fl[i];
            end
        end
        restore_free_list = restore_valid ? (win_fl | retire_free) : '0;
    end

    always_comb begin
        first_free = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (!valid[i]) first_free = DEPTH'(1) << i;
    end

    assign alloc_grant = alloc_req && (free_count != '0) && !restore_valid;
    assign alloc_tag   = alloc_grant ? first_free : '0;
    assign cur_b_mask  = keep | alloc_tag;

    always_comb begin
        next_free = CNT_W'(DEPTH);
        for (int i = 0; i < DEPTH; i++)
            if (cur_b_mask[i]) next_free = next_free - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) free_count <= CNT_W'(DEPTH);
        else       free_count <= next_free;
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
        branch_checkpoint_slot #(
            .DEPTH(DEPTH), .ROB_IDX_W(ROB_IDX_W), .LSQ_IDX_W(LSQ_IDX_W),
            .PREGS(PREGS), .MAP_W(MAP_W), .ADDR_W(ADDR_W)
        ) u_slot (
            .clock             (clock),
            .reset             (reset),
            .alloc_en          (alloc_tag[s]),
            .keep              (keep[s]),
            .dep_init          (keep),
            .clear_bits        (clear_mask),
            .alloc_rob_tail    (alloc_rob_tail),
            .alloc_lsq_tail    (alloc_lsq_tail),
            .alloc_free_list   (alloc_free_list),
            .alloc_map_table   (alloc_map_table),
            .alloc_recovery_pc (alloc_recovery_pc),
            .retire_free       (retire_free),
            .valid             (valid[s]),
            .dep               (slot_dep[s]),
            .rob_tail          (slot_rob[s]),
            .lsq_tail          (slot_lsq[s]),
            .free_list         (slot_fl[s]),
            .map_table         (slot_map[s]),
            .recovery_pc       (slot_pc[s])
        );
    end
endmodule
